control_unit: RTL and testbench

Multi-cycle RV64I control unit for the single-issue core; sits directly upstream of the datapath, consuming its decoded fields and ALU flags and driving every mux select, enable and ALU control it needs. It also owns the instruction- and data-memory request handshakes and sequences each instruction through fetch, decode, execute, memory and writeback states.

---
 rtl/control_unit_pkg.sv | 114 +++++++++++
 rtl/control_unit_branch_unit.sv | 22 ++
 rtl/control_unit.sv | 130 +++++++++++++
 tb/tb_control_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the multi-cycle RV64I control unit: opcodes, state
// encoding, the decoded control bundle and the store byte-lane lookup.
package control_unit_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    typedef struct packed {
        logic       alua_src;
        logic       alub_src;
        logic       aluy_src;
        logic       alupc_src;
        logic       arithmetic;
        logic       carry_in;
        logic [2:0] alu_src;
        logic [2:0] read_data_src;
        logic [1:0] write_register_src;
        logic [7:0] byte_enable;
        logic [2:0] funct3;
        logic       is_exec;
        logic       is_branch;
        logic       is_jump;
        logic       is_load;
        logic       is_store;
    } ctrl_t;

    function automatic logic [7:0] store_byte_enable(input logic [1:0] size);
        case (size)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Anything not recognised (including SYSTEM) leaves is_exec/is_load/is_store
    // clear, which is what sends DECODE to HALT.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic       funct7);
        ctrl_t c;
        c        = '0;
        c.funct3 = funct3;
        case (opcode)
            OPC_OP, OPC_OP_32: begin
                c.is_exec            = 1'b1;
                c.alub_src           = 1'b1;
                c.aluy_src           = (opcode == OPC_OP_32);
                c.alu_src            = funct3;
                c.arithmetic         = funct7;
                c.write_register_src = 2'b10;
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                c.is_exec            = 1'b1;
                c.aluy_src           = (opcode == OPC_OP_IMM_32);
                c.alu_src            = funct3;
                c.arithmetic         = (funct3[1:0] == 2'b01) ? funct7 : 1'b0;
                c.write_register_src = 2'b10;
            end
            OPC_LUI: begin
                c.is_exec            = 1'b1;
                c.write_register_src = 2'b10;
            end
            OPC_AUIPC: begin
                c.is_exec            = 1'b1;
                c.alua_src           = 1'b1;
                c.write_register_src = 2'b10;
            end
            OPC_JAL, OPC_JALR: begin
                c.is_exec            = 1'b1;
                c.is_jump            = 1'b1;
                c.alupc_src          = (opcode == OPC_JALR);
                c.write_register_src = 2'b01;
            end
            OPC_BRANCH: begin
                c.is_exec    = 1'b1;
                c.is_branch  = 1'b1;
                c.alub_src   = 1'b1;
                c.arithmetic = 1'b1;
            end
            OPC_LOAD: begin
                c.is_load       = 1'b1;
                c.read_data_src = {~funct3[2], funct3[1:0]};
            end
            OPC_STORE: begin
                c.is_store    = 1'b1;
                c.byte_enable = store_byte_enable(funct3[1:0]);
            end
            default: ;
        endcase
        c.carry_in = (c.alu_src == 3'b000) ? c.arithmetic : 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/control_unit_branch_unit.sv
// Combinational branch resolution from funct3 and the ALU subtract flags.
module branch_unit (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry_out,
    input  logic       overflow,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000: taken = zero;
            3'b001: taken = !zero;
            3'b100: taken = negative ^ overflow;
            3'b101: taken = !(negative ^ overflow);
            3'b110: taken = !carry_out;
            3'b111: taken = carry_out;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV64I control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects plus instruction/data memory handshakes.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry_out,
    input  logic       overflow,
    output logic       inst_mem_enable,
    input  logic       inst_mem_ack,
    output logic       data_mem_read_enable,
    output logic       data_mem_write_enable,
    output logic [7:0] data_mem_byte_enable,
    input  logic       data_mem_ack,
    output logic       alua_src,
    output logic       alub_src,
    output logic       aluy_src,
    output logic       carry_in,
    output logic       arithmetic,
    output logic       alupc_src,
    output logic       pc_src,
    output logic       pc_enable,
    output logic       write_register_enable,
    output logic [2:0] alu_src,
    output logic [2:0] read_data_src,
    output logic [1:0] write_register_src,
    output logic       halted
);
    state_t state;
    ctrl_t  ctrl;
    logic   pc_enable_q;
    logic   taken;

    branch_unit u_branch (
        .funct3    (ctrl.funct3),
        .zero      (zero),
        .negative  (negative),
        .carry_out (carry_out),
        .overflow  (overflow),
        .taken     (taken)
    );

    assign alua_src             = ctrl.alua_src;
    assign alub_src             = ctrl.alub_src;
    assign aluy_src             = ctrl.aluy_src;
    assign carry_in             = ctrl.carry_in;
    assign arithmetic           = ctrl.arithmetic;
    assign alupc_src            = ctrl.alupc_src;
    assign alu_src              = ctrl.alu_src;
    assign read_data_src        = ctrl.read_data_src;
    assign write_register_src   = ctrl.write_register_src;
    assign data_mem_byte_enable = ctrl.byte_enable;
    assign pc_src               = ctrl.is_jump | (ctrl.is_branch & taken);

    // A store retires in the very cycle its ack arrives, so that pulse cannot
    // come from a register.
    assign pc_enable = pc_enable_q |
                       ((state == S_MEMORY) & data_mem_write_enable & data_mem_ack);

    always_ff @(posedge clock) begin
        if (reset) begin
            state                 <= S_FETCH;
            ctrl                  <= '0;
            inst_mem_enable       <= 1'b0;
            data_mem_read_enable  <= 1'b0;
            data_mem_write_enable <= 1'b0;
            pc_enable_q           <= 1'b0;
            write_register_enable <= 1'b0;
            halted                <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (inst_mem_enable && inst_mem_ack) begin
                        inst_mem_enable <= 1'b0;
                        ctrl            <= decode_ctrl(opcode, funct3, funct7);
                        state           <= S_DECODE;
                    end else begin
                        inst_mem_enable <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (ctrl.is_load) begin
                        data_mem_read_enable <= 1'b1;
                        state                <= S_MEMORY;
                    end else if (ctrl.is_store) begin
                        data_mem_write_enable <= 1'b1;
                        state                 <= S_MEMORY;
                    end else if (ctrl.is_exec) begin
                        write_register_enable <= !ctrl.is_branch;
                        pc_enable_q           <= 1'b1;
                        state                 <= S_EXECUTE;
                    end else begin
                        halted <= 1'b1;
                        ctrl   <= '0;
                        state  <= S_HALT;
                    end
                end
                S_EXECUTE, S_WRITEBACK: begin
                    write_register_enable <= 1'b0;
                    pc_enable_q           <= 1'b0;
                    inst_mem_enable       <= 1'b1;
                    state                 <= S_FETCH;
                end
                S_MEMORY: begin
                    if (data_mem_ack) begin
                        if (data_mem_read_enable) begin
                            data_mem_read_enable  <= 1'b0;
                            write_register_enable <= 1'b1;
                            pc_enable_q           <= 1'b1;
                            state                 <= S_WRITEBACK;
                        end else begin
                            data_mem_write_enable <= 1'b0;
                            inst_mem_enable       <= 1'b1;
                            state                 <= S_FETCH;
                        end
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios then random
// instructions checked against a behavioural model of the instruction set.
module tb_control_unit;
    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero, negative, carry_out, overflow;
    logic       inst_mem_enable, inst_mem_ack;
    logic       data_mem_read_enable, data_mem_write_enable;
    logic [7:0] data_mem_byte_enable;
    logic       data_mem_ack;
    logic       alua_src, alub_src, aluy_src, carry_in, arithmetic, alupc_src;
    logic       pc_src, pc_enable, write_register_enable;
    logic [2:0] alu_src, read_data_src;
    logic [1:0] write_register_src;
    logic       halted;

    control_unit dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
        .inst_mem_enable(inst_mem_enable), .inst_mem_ack(inst_mem_ack),
        .data_mem_read_enable(data_mem_read_enable), .data_mem_write_enable(data_mem_write_enable),
        .data_mem_byte_enable(data_mem_byte_enable), .data_mem_ack(data_mem_ack),
        .alua_src(alua_src), .alub_src(alub_src), .aluy_src(aluy_src), .carry_in(carry_in),
        .arithmetic(arithmetic), .alupc_src(alupc_src), .pc_src(pc_src), .pc_enable(pc_enable),
        .write_register_enable(write_register_enable), .alu_src(alu_src),
        .read_data_src(read_data_src), .write_register_src(write_register_src), .halted(halted)
    );

    always #5 clock = ~clock;

    localparam logic [2:0] K_ALU = 3'd0, K_JUMP = 3'd1, K_BRANCH = 3'd2,
                           K_LOAD = 3'd3, K_STORE = 3'd4, K_HALT = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic       alua, alub, aluy, alupc, arith, cin;
        logic [2:0] alu_src, rds;
        logic [1:0] wrs;
        logic [7:0] be;
    } exp_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        exp_t e;
        int   bytes;
        e = '0;
        case (opc)
            7'b0110011, 7'b0111011: begin
                e.kind = K_ALU; e.alub = 1; e.alu_src = f3; e.arith = f7; e.wrs = 2'b10;
                e.aluy = (opc == 7'b0111011);
            end
            7'b0010011, 7'b0011011: begin
                e.kind = K_ALU; e.alu_src = f3; e.wrs = 2'b10;
                e.arith = (f3 == 3'd1 || f3 == 3'd5) ? f7 : 1'b0;
                e.aluy = (opc == 7'b0011011);
            end
            7'b0110111: begin e.kind = K_ALU; e.wrs = 2'b10; end
            7'b0010111: begin e.kind = K_ALU; e.wrs = 2'b10; e.alua = 1; end
            7'b1101111: begin e.kind = K_JUMP; e.wrs = 2'b01; end
            7'b1100111: begin e.kind = K_JUMP; e.wrs = 2'b01; e.alupc = 1; end
            7'b1100011: begin e.kind = K_BRANCH; e.alub = 1; e.arith = 1; end
            7'b0000011: begin e.kind = K_LOAD; e.rds = {~f3[2], f3[1:0]}; end
            7'b0100011: begin
                e.kind = K_STORE;
                bytes  = 1 << f3[1:0];
                e.be   = 8'((16'd1 << bytes) - 16'd1);
            end
            default: e.kind = K_HALT;
        endcase
        e.cin = (e.alu_src == 3'd0) ? e.arith : 1'b0;
        return e;
    endfunction

    // Flags come from a real a-b subtraction; the expected outcome comes from
    // comparing a and b directly.
    task automatic run_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, input int fw, input int mw,
                             input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [64:0] s;
        logic exp_taken, exp_pcsrc;
        int cyc, fc, dc, wre_n, rd_n, wr_n, exp_cyc;
        bit started, done;
        e = model(opc, f3, f7);
        opcode = opc; funct3 = f3; funct7 = f7;
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        carry_out = s[64];
        zero      = (s[63:0] == 64'd0);
        negative  = s[63];
        overflow  = (a[63] != b[63]) && (s[63] != a[63]);
        case (f3)
            3'b000:  exp_taken = (a == b);
            3'b001:  exp_taken = (a != b);
            3'b100:  exp_taken = ($signed(a) < $signed(b));
            3'b101:  exp_taken = ($signed(a) >= $signed(b));
            3'b110:  exp_taken = (a < b);
            3'b111:  exp_taken = (a >= b);
            default: exp_taken = 1'b0;
        endcase
        exp_pcsrc = (e.kind == K_JUMP) || (e.kind == K_BRANCH && exp_taken);
        exp_cyc = ((e.kind == K_LOAD) ? 4 : 3) + fw +
                  ((e.kind == K_LOAD || e.kind == K_STORE) ? mw : 0);
        cyc = 0; fc = 0; dc = 0; wre_n = 0; rd_n = 0; wr_n = 0; started = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            inst_mem_ack = 1'b0;
            data_mem_ack = 1'b0;
            if (inst_mem_enable) begin
                if (fc == fw) inst_mem_ack = 1'b1; else fc++;
            end
            if (data_mem_read_enable || data_mem_write_enable) begin
                if (dc == mw) data_mem_ack = 1'b1; else dc++;
            end
            #1;
            if (inst_mem_enable) started = 1;
            if (started) cyc++;
            if (data_mem_read_enable) begin
                rd_n++;
                if (rd_n == 1) chk({tag, "_rds"}, read_data_src, e.rds);
            end
            if (data_mem_write_enable) begin
                wr_n++;
                if (wr_n == 1) chk({tag, "_be"}, data_mem_byte_enable, e.be);
            end
            if (write_register_enable) wre_n++;
            if (pc_enable) begin
                done = 1;
                chk({tag, "_sel"},
                    {alua_src, alub_src, aluy_src, alupc_src, arithmetic, carry_in, alu_src},
                    {e.alua, e.alub, e.aluy, e.alupc, e.arith, e.cin, e.alu_src});
                chk({tag, "_pc_src"}, pc_src, exp_pcsrc);
                if (write_register_enable) begin
                    if (e.kind == K_ALU) chk({tag, "_wrs"}, write_register_src[1], 1'b1);
                    else chk({tag, "_wrs"}, write_register_src, e.wrs);
                end
            end
            @(posedge clock); #1;
        end
        inst_mem_ack = 1'b0;
        data_mem_ack = 1'b0;
        chk({tag, "_retired"}, done, 1'b1);
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_wre_pulses"}, wre_n,
            (e.kind == K_ALU || e.kind == K_JUMP || e.kind == K_LOAD) ? 1 : 0);
        if (e.kind == K_LOAD)  chk({tag, "_rd_hold"}, rd_n, mw + 1);
        if (e.kind == K_STORE) chk({tag, "_wr_hold"}, wr_n, mw + 1);
    endtask

    function automatic logic [31:0] all_outs();
        return {inst_mem_enable, data_mem_read_enable, data_mem_write_enable, data_mem_byte_enable,
                alua_src, alub_src, aluy_src, carry_in, arithmetic, alupc_src, pc_src, pc_enable,
                write_register_enable, alu_src, read_data_src, write_register_src, halted};
    endfunction

    task automatic run_halt(input string tag, input logic [6:0] opc);
        bit seen;
        int bad;
        opcode = opc; funct3 = 3'd0; funct7 = 1'b0;
        seen = 0; bad = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            inst_mem_ack = inst_mem_enable;
            #1;
            if (pc_enable || write_register_enable) bad++;
            seen = halted;
            @(posedge clock); #1;
        end
        chk({tag, "_halted"}, seen, 1'b1);
        chk({tag, "_no_retire"}, bad, 0);
        for (int i = 0; i < 4; i++) begin
            inst_mem_ack = (i % 2 == 0);
            #1;
            chk({tag, "_absorb"},
                {halted, inst_mem_enable, data_mem_read_enable, data_mem_write_enable,
                 pc_enable, write_register_enable}, 6'b100000);
            @(posedge clock); #1;
        end
        inst_mem_ack = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        chk({tag, "_reset_outs"}, all_outs(), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] legal [11];
        logic [2:0] br_f3 [6];
        logic [63:0] a, b;
        logic [6:0] opc;
        logic [2:0] f3;
        int sel;
        legal = '{7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0110111, 7'b0010111,
                  7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        reset = 1'b1; opcode = '0; funct3 = '0; funct7 = 1'b0;
        zero = 0; negative = 0; carry_out = 0; overflow = 0;
        inst_mem_ack = 0; data_mem_ack = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_outs", all_outs(), 32'd0);
        reset = 1'b0;

        run_instr("addi", 7'b0010011, 3'd0, 1'b0, 0, 0, 64'd0, 64'd5);
        run_instr("blt_taken", 7'b1100011, 3'd4, 1'b0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_instr("blt_ovf", 7'b1100011, 3'd4, 1'b0, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFF);
        run_instr("lb_wait3", 7'b0000011, 3'd0, 1'b0, 0, 3, 64'd0, 64'd0);
        run_instr("sh_wait2", 7'b0100011, 3'd1, 1'b0, 0, 2, 64'd0, 64'd0);
        run_instr("srai_fw1", 7'b0010011, 3'd5, 1'b1, 1, 0, 64'd0, 64'd0);
        run_halt("illegal", 7'b0000000);
        run_halt("ecall", 7'b1110011);

        // Reset lands while a load is waiting on data memory; the late ack
        // must not retire anything.
        opcode = 7'b0000011; funct3 = 3'd2; funct7 = 1'b0;
        for (int i = 0; i < 20 && !data_mem_read_enable; i++) begin
            inst_mem_ack = inst_mem_enable;
            @(posedge clock); #1;
        end
        inst_mem_ack = 1'b0;
        chk("midmem_read_req", data_mem_read_enable, 1'b1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        data_mem_ack = 1'b1;
        #1;
        chk("midmem_dropped", {data_mem_read_enable, pc_enable, write_register_enable}, 3'b000);
        @(posedge clock); #1;
        data_mem_ack = 1'b0;
        #1;
        chk("midmem_refetch",
            {inst_mem_enable, pc_enable, write_register_enable, halted}, 4'b1000);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 10);
            opc = legal[sel];
            f3  = 3'($urandom_range(0, 7));
            if (opc == 7'b1100011) f3 = br_f3[$urandom_range(0, 5)];
            if (opc == 7'b0100011) f3 = 3'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {~a[63], a[62:0]};
                default: ;
            endcase
            run_instr($sformatf("rnd%0d_op%02h_f%0d", n, opc, f3), opc, f3,
                      1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
